fir_serial_n: RTL and testbench
===============================

# fir_serial_n

Time-multiplexed, multi-channel FIR filter. A single multiply-accumulate unit is shared across TAPS coefficients and CHANNELS independent sample histories. Samples enter and results leave over valid/ready handshakes, and coefficients can be rewritten at run time. It replaces the fully parallel tapped-delay FIR wherever area matters more than throughput, and sits in the same sample path: synchronised input in, filtered output out.

## Interface
Parameters:
- N, 32: sample, coefficient and output width, signed two's complement.
- TAPS, 4: number of coefficients; must be >= 2.
- CHANNELS, 1: number of independent channel histories; must be >= 1.
- FRAC, 0: arithmetic right shift applied to the accumulator before output; must be < N.

Ports (CW = max(1, $clog2(CHANNELS)), TW = $clog2(TAPS)):
- clk  in  1  single system clock; all state changes on the rising edge.
- rst  in  1  asynchronous reset, active-low.
- ena  in  1  clock enable; when low, all registers hold and x_ready and y_valid read 0.
- x_in  in  N  input sample, signed.
- x_ch  in  CW  channel of x_in; values >= CHANNELS are dropped (handshake completes, nothing computed).
- x_valid  in  1  x_in/x_ch valid.
- x_ready  out  1  block can accept a sample.
- y_out  out  N  filtered result, signed.
- y_ch  out  CW  channel of y_out.
- y_valid  out  1  y_out/y_ch valid.
- y_ready  in  1  downstream accepts the result.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  TW  tap index k to write.
- coef_data  in  N  signed coefficient b[k].

## Operation
- State machine with three states:
  - IDLE -> MAC on input accept (x_valid && x_ready, channel in range).
  - MAC -> OUT after TAPS MAC cycles.
  - OUT -> IDLE on y_valid && y_ready.
- x_ready = (state==IDLE) && ena && !coef_we && rst. y_valid is high only in OUT, gated by ena.
- On accept, the sample is shifted into history h[x_ch][0]; older entries move to k+1 and h[x_ch][TAPS-1] is discarded. The channel is latched for y_ch.
- MAC cycle k (k = 0..TAPS-1) computes acc += b[k]*h[ch][k]. acc is cleared on accept.
- Arithmetic widths:
  - Product: 2N signed.
  - Accumulator: 2N+TW signed, never overflows.
  - Result: acc >>> FRAC, reduced to N bits (see Configuration), loaded into y_out on the last MAC edge.
- Coefficients are shared by all channels. A write lands only in IDLE; coef_we in MAC or OUT is ignored. In IDLE, a write has priority over a sample (x_ready is 0 that cycle).
- Out-of-range x_ch: the accept handshake completes, the state stays IDLE, and no history changes.
- Reset (async, any state, including mid-MAC):
  - State -> IDLE; all history and coefficients -> 0; acc -> 0.
  - y_out -> 0, y_ch -> 0, y_valid -> 0, x_ready -> 0 while rst is low.
  - Any in-flight result is discarded.

## Timing
- Accept at edge E0. MAC products are added at edges E1..E_TAPS. y_out, y_ch and y_valid are valid after E_TAPS.
- Latency: TAPS cycles from accept to y_valid.
- With y_ready held high: OUT lasts 1 cycle, x_ready returns after E_TAPS+1, giving one sample per TAPS+2 cycles.
- With y_ready low: y_out, y_ch and y_valid hold indefinitely, x_ready stays 0, and no sample is lost.
- ena low for any number of cycles stretches the schedule by exactly that many cycles with no other effect.

## Configuration
- FIR_SATURATE_EN defined: the shifted accumulator is clamped to [-2^(N-1), 2^(N-1)-1].
- FIR_SATURATE_EN undefined: the shifted accumulator is truncated to its low N bits (wraps).

## Structure
- Package fir_pkg holds:
  - State enum fir_state_t {FIR_IDLE, FIR_MAC, FIR_OUT}.
  - Accumulator-width constant function.
  - Saturate/truncate function, selected by FIR_SATURATE_EN.
- Sub-module fir_coef_bank: TAPS x N coefficient register file with async active-low reset, one write port and one combinational read port indexed by the MAC counter.

## Test plan
- Impulse: TAPS=4, b = {1,2,3,4} (b[0]=1), ch0 input 1,0,0,0,0 -> y = 1,2,3,4,0; each y_valid arrives 4 cycles after its accept.
- Channel interleave: CHANNELS=2, ch0 impulse and ch1 constant 5, alternating -> ch0 gives 1,2,3,4; ch1 gives 5,15,30,50; y_ch correct on every result.
- Backpressure: y_ready low for 10 cycles during OUT -> y_out and y_valid stable, x_ready 0, then the result transfers once and the next sample is accepted.
- Overflow: N=8, TAPS=4, all b = 127, four samples of 127 -> 4th output is 127 with FIR_SATURATE_EN, 4 (0xFC04 truncated) without.
- Reset mid-MAC: rst low at E2 of a MAC -> y_valid 0 immediately and no result appears; after release, an impulse with default coefficients gives y = 0.
- Write/sample collision: coef_we and x_valid both high in IDLE -> x_ready 0, coefficient written; sample accepted next cycle and filtered with the new coefficient.

Source files
------------

// File: rtl/fir_serial_n_pkg.sv
// fir_pkg: shared types and helpers for the serial multi-channel FIR.
// Macro FIR_SATURATE_EN selects clamping instead of wrapping in fir_reduce.
package fir_pkg;

  typedef enum logic [1:0] {
    FIR_IDLE,
    FIR_MAC,
    FIR_OUT
  } fir_state_t;

  // Working widths of the output reduction helper.
  localparam int FIR_RED_W = 128;
  localparam int FIR_OUT_W = 64;

  // Accumulator wide enough that TAPS full-scale products never overflow.
  function automatic int fir_acc_w(int n, int taps);
    return 2 * n + $clog2(taps);
  endfunction

  // Reduce a sign-extended shifted accumulator to n bits.
  // The result is sign-extended to FIR_OUT_W; callers keep the low n bits.
  function automatic logic signed [FIR_OUT_W-1:0] fir_reduce(
    logic signed [FIR_RED_W-1:0] v,
    int                          n
  );
    logic signed [FIR_RED_W-1:0] r;
`ifdef FIR_SATURATE_EN
    logic signed [FIR_RED_W-1:0] hi;
    logic signed [FIR_RED_W-1:0] lo;
    hi = (FIR_RED_W'(1) <<< (n - 1)) - FIR_RED_W'(1);
    lo = -hi - FIR_RED_W'(1);
    if (v > hi) r = hi;
    else if (v < lo) r = lo;
    else r = v;
`else
    r = (v <<< (FIR_RED_W - n)) >>> (FIR_RED_W - n);
`endif
    return r[FIR_OUT_W-1:0];
  endfunction

endpackage

// File: rtl/fir_serial_n_if.sv
// fir_serial_n_if: sample in, result out and coefficient write bundle.
// master drives x_*, y_ready, coef_*; slave drives x_ready, y_*.
interface fir_serial_n_if #(
  parameter int N        = 32,
  parameter int TAPS     = 4,
  parameter int CHANNELS = 1
);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int TW = $clog2(TAPS);

  logic signed [N-1:0]  x_in;
  logic [CW-1:0]        x_ch;
  logic                 x_valid;
  logic                 x_ready;
  logic signed [N-1:0]  y_out;
  logic [CW-1:0]        y_ch;
  logic                 y_valid;
  logic                 y_ready;
  logic                 coef_we;
  logic [TW-1:0]        coef_addr;
  logic signed [N-1:0]  coef_data;

  modport master (
    output x_in, x_ch, x_valid, y_ready,
    output coef_we, coef_addr, coef_data,
    input  x_ready, y_out, y_ch, y_valid
  );

  modport slave (
    input  x_in, x_ch, x_valid, y_ready,
    input  coef_we, coef_addr, coef_data,
    output x_ready, y_out, y_ch, y_valid
  );

endinterface

// File: rtl/fir_serial_n_coef_bank.sv
// fir_coef_bank: TAPS x N coefficient registers, one write, one async read.
// Ports: clk, rst (async active-low), we/waddr/wdata, raddr -> rdata.
module fir_coef_bank #(
  parameter int N    = 32,
  parameter int TAPS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [$clog2(TAPS)-1:0]  waddr,
  input  logic signed [N-1:0]      wdata,
  input  logic [$clog2(TAPS)-1:0]  raddr,
  output logic signed [N-1:0]      rdata
);

  logic signed [N-1:0] b_q [TAPS];
  logic signed [N-1:0] b_d [TAPS];

  always_comb begin
    b_d = b_q;
    if (we) b_d[waddr] = wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < TAPS; k++) b_q[k] <= '0;
    end else begin
      b_q <= b_d;
    end
  end

  assign rdata = b_q[raddr];

endmodule

// File: rtl/fir_serial_n.sv
// fir_serial_n: one shared MAC filtering CHANNELS histories over TAPS taps.
// Ports: clk, rst (async active-low), ena, bus (fir_serial_n_if.slave).
// Macro FIR_SATURATE_EN: clamp the result instead of wrapping it.
module fir_serial_n
  import fir_pkg::*;
#(
  parameter int N        = 32,
  parameter int TAPS     = 4,
  parameter int CHANNELS = 1,
  parameter int FRAC     = 0
) (
  input logic            clk,
  input logic            rst,
  input logic            ena,
  fir_serial_n_if.slave  bus
);

  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int TW = $clog2(TAPS);
  localparam int AW = fir_acc_w(N, TAPS);
  localparam logic [TW-1:0] LAST = TW'(TAPS - 1);

  fir_state_t state_q, state_d;

  logic [TW-1:0]        cnt_q, cnt_d;
  logic [CW-1:0]        ch_q, ch_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic signed [N-1:0]  y_q, y_d;
  logic signed [N-1:0]  hist_q [CHANNELS][TAPS];
  logic signed [N-1:0]  hist_d [CHANNELS][TAPS];

  logic                 coef_wr;
  logic                 mac_en;
  logic                 x_fire;
  logic                 ch_ok;
  logic                 x_go;
  logic                 y_fire;
  logic                 last;
  logic signed [N-1:0]  coef_rd;
  logic signed [N-1:0]  hsel;
  logic signed [2*N-1:0] prod;
  logic signed [AW-1:0] acc_sum;
  logic signed [AW-1:0] acc_sh;
  logic signed [FIR_RED_W-1:0] red_in;
  logic signed [FIR_OUT_W-1:0] red;
  logic                 unused_red;

  fir_coef_bank #(
    .N    (N),
    .TAPS (TAPS)
  ) u_coef (
    .clk   (clk),
    .rst   (rst),
    .we    (coef_wr),
    .waddr (bus.coef_addr),
    .wdata (bus.coef_data),
    .raddr (cnt_q),
    .rdata (coef_rd)
  );

  assign x_fire = bus.x_valid && bus.x_ready;
  // Out-of-range channels complete the handshake but start nothing.
  assign ch_ok  = {1'b0, bus.x_ch} < (CW+1)'(CHANNELS);
  assign x_go   = x_fire && ch_ok;
  assign y_fire = bus.y_valid && bus.y_ready;
  assign last   = cnt_q == LAST;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= FIR_IDLE;
    else if (ena) state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FIR_IDLE: if (x_go) state_d = FIR_MAC;
      FIR_MAC:  if (mac_en && last) state_d = FIR_OUT;
      FIR_OUT:  if (y_fire) state_d = FIR_IDLE;
      default:  state_d = FIR_IDLE;
    endcase
  end

  // A coefficient write in IDLE wins over a sample that cycle.
  always_comb begin
    bus.x_ready = 1'b0;
    bus.y_valid = 1'b0;
    coef_wr     = 1'b0;
    mac_en      = 1'b0;
    unique case (1'b1)
      state_q == FIR_IDLE: begin
        bus.x_ready = ena && !bus.coef_we && rst;
        coef_wr     = ena && bus.coef_we;
      end
      state_q == FIR_MAC: mac_en      = ena;
      state_q == FIR_OUT: bus.y_valid = ena;
      default: ;
    endcase
  end

  always_comb begin
    hsel = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (CW'(c) == ch_q) hsel = hist_q[c][cnt_q];
    end
  end

  assign prod    = hsel * coef_rd;
  assign acc_sum = acc_q + AW'(prod);
  assign acc_sh  = acc_sum >>> FRAC;
  assign red_in  = {{(FIR_RED_W-AW){acc_sh[AW-1]}}, acc_sh};
  assign red     = fir_reduce(red_in, N);
  assign unused_red = ^red[FIR_OUT_W-1:N];

  always_comb begin
    cnt_d  = cnt_q;
    ch_d   = ch_q;
    acc_d  = acc_q;
    y_d    = y_q;
    hist_d = hist_q;
    if (x_go) begin
      cnt_d = '0;
      ch_d  = bus.x_ch;
      acc_d = '0;
      for (int c = 0; c < CHANNELS; c++) begin
        if (CW'(c) == bus.x_ch) begin
          hist_d[c][0] = bus.x_in;
          for (int k = 1; k < TAPS; k++) hist_d[c][k] = hist_q[c][k-1];
        end
      end
    end
    if (mac_en) begin
      acc_d = acc_sum;
      cnt_d = cnt_q + 1'b1;
      if (last) begin
        cnt_d = '0;
        y_d   = red[N-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      ch_q  <= '0;
      acc_q <= '0;
      y_q   <= '0;
      for (int c = 0; c < CHANNELS; c++)
        for (int k = 0; k < TAPS; k++) hist_q[c][k] <= '0;
    end else if (ena) begin
      cnt_q  <= cnt_d;
      ch_q   <= ch_d;
      acc_q  <= acc_d;
      y_q    <= y_d;
      hist_q <= hist_d;
    end
  end

  assign bus.y_out = y_q;
  assign bus.y_ch  = ch_q;

endmodule

// File: tb/tb_fir_serial_n.sv
// tb_fir_serial_n: directed stimulus with queued expectations and a monitor.
// Covers impulse, interleave, backpressure, stall, collision, reset, overflow.
module tb_fir_serial_n;

  localparam int N    = 8;
  localparam int TAPS = 4;
  localparam int CH   = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ena = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  fir_serial_n_if #(.N(N), .TAPS(TAPS), .CHANNELS(CH)) bus ();

  fir_serial_n #(
    .N        (N),
    .TAPS     (TAPS),
    .CHANNELS (CH),
    .FRAC     (0)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .ena (ena),
    .bus (bus.slave)
  );

  typedef struct {
    logic signed [N-1:0] y;
    logic [1:0]          ch;
    int                  acc;
    int                  lat;
  } exp_t;

  exp_t q[$];
  exp_t e;
  bit   seen = 1'b0;

  int imp_x [5] = '{1, 0, 0, 0, 0};
  int imp_y [5] = '{1, 2, 3, 4, 0};
  int iv_c  [8] = '{0, 1, 0, 1, 0, 1, 0, 1};
  int iv_x  [8] = '{1, 5, 0, 5, 0, 5, 0, 5};
  int iv_y  [8] = '{1, 5, 2, 15, 3, 30, 4, 50};
`ifdef FIR_SATURATE_EN
  int ov_y  [4] = '{127, 127, 127, 127};
`else
  int ov_y  [4] = '{1, 2, 3, 4};
`endif

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst && bus.y_valid) begin
      if (!seen && q.size() > 0 && q[0].lat >= 0)
        chk("latency", cyc - q[0].acc, q[0].lat);
      seen = 1'b1;
      if (bus.y_ready) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_y actual=%0d required=none", bus.y_out);
        end else begin
          e = q.pop_front();
          chk("y_out", bus.y_out, e.y);
          chk("y_ch", 32'(bus.y_ch), 32'(e.ch));
        end
        seen = 1'b0;
      end
    end
  end

  task automatic send(input int ch, input int x, input int y,
                      input int lat, input bit push);
    int n = 0;
    bit ok = 1'b0;
    bus.x_ch    = 2'(ch);
    bus.x_in    = N'(x);
    bus.x_valid = 1'b1;
    while (!ok && n < 200) begin
      @(negedge clk);
      if (bus.x_ready) begin
        ok = 1'b1;
        if (push) q.push_back('{N'(y), 2'(ch), cyc + 1, lat});
      end
      @(posedge clk);
      #1;
      n++;
    end
    bus.x_valid = 1'b0;
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL send_timeout ch=%0d actual=no_accept required=accept", ch);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=%0d pending required=0", q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wcoef(input int k, input int v);
    bus.coef_we   = 1'b1;
    bus.coef_addr = 2'(k);
    bus.coef_data = N'(v);
    @(posedge clk);
    #1;
    bus.coef_we = 1'b0;
  endtask

  initial begin
    bus.x_in      = '0;
    bus.x_ch      = '0;
    bus.x_valid   = 1'b0;
    bus.y_ready   = 1'b1;
    bus.coef_we   = 1'b0;
    bus.coef_addr = '0;
    bus.coef_data = '0;

    #12;
    chk("rst_x_ready", 32'(bus.x_ready), 0);
    chk("rst_y_valid", 32'(bus.y_valid), 0);
    chk("rst_y_out", bus.y_out, 0);
    chk("rst_y_ch", 32'(bus.y_ch), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    for (int k = 0; k < TAPS; k++) wcoef(k, k + 1);

    for (int i = 0; i < 5; i++) send(0, imp_x[i], imp_y[i], 4, 1'b1);

    for (int i = 0; i < 8; i++) send(iv_c[i], iv_x[i], iv_y[i], 4, 1'b1);

    wait_idle();
    bus.y_ready = 1'b0;
    send(1, 5, 50, 4, 1'b1);
    for (int n = 0; n < 20 && !bus.y_valid; n++) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_y_valid", 32'(bus.y_valid), 1);
      chk("bp_y_out", bus.y_out, 50);
      chk("bp_x_ready", 32'(bus.x_ready), 0);
    end
    @(posedge clk);
    #1;
    bus.y_ready = 1'b1;
    send(0, 2, 2, 4, 1'b1);

    send(0, 0, 4, 7, 1'b1);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    ena = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    ena = 1'b1;

    wait_idle();
    bus.coef_we   = 1'b1;
    bus.coef_addr = 2'd0;
    bus.coef_data = N'(10);
    bus.x_ch      = 2'd0;
    bus.x_in      = N'(3);
    bus.x_valid   = 1'b1;
    @(negedge clk);
    chk("collide_x_ready", 32'(bus.x_ready), 0);
    @(posedge clk);
    #1;
    bus.coef_we = 1'b0;
    send(0, 3, 36, 4, 1'b1);

    send(1, 1, 0, 4, 1'b1);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    #1;
    chk("mid_rst_y_valid", 32'(bus.y_valid), 0);
    chk("mid_rst_x_ready", 32'(bus.x_ready), 0);
    chk("mid_rst_y_out", bus.y_out, 0);
    q.delete(q.size() - 1);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;

    send(0, 1, 0, 4, 1'b1);
    send(1, 7, 0, 4, 1'b1);
    wait_idle();
    for (int k = 0; k < TAPS; k++) wcoef(k, k + 1);
    send(1, 2, 16, 4, 1'b1);

    send(3, 100, 0, -1, 1'b0);

    wait_idle();
    for (int k = 0; k < TAPS; k++) wcoef(k, 127);
    for (int i = 0; i < 4; i++) send(2, 127, ov_y[i], 4, 1'b1);

    wait_idle();
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
